// File: rtl/gameover_pkg.sv
// Shared types and constants for the game-over overlay sequencer.
// Holds the FSM state type, the frame counter width and the saturating
// reveal-step helper used by gameover_seq.
package gameover_pkg;

  localparam int unsigned GO_H_DEFAULT = 512;
  localparam int unsigned FRAME_CNT_W  = 8;

  // Encodings are visible on state_dbg; 7 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    REVEAL = 3'd2,
    HOLD   = 3'd3,
    ARMED  = 3'd4,
    EXIT   = 3'd5,
    CLEAR  = 3'd6
  } go_state_t;

  // One wipe step: add in 11 bits so the sum cannot wrap, then clamp at the
  // overlay height.
  function automatic logic [9:0] reveal_step(input logic [9:0]  rows,
                                             input logic [10:0] step,
                                             input logic [10:0] limit);
    logic [10:0] sum;
    sum = {1'b0, rows} + step;
    if (sum >= limit) begin
      return limit[9:0];
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/go_frame_counter.sv
// Frame-tick counter: synchronous clear, increments on tick, saturates at
// all-ones, and flags when the count equals a terminal value.
module go_frame_counter
  import gameover_pkg::*;
#(
  parameter int unsigned W = FRAME_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  // Clear has priority over counting; hold at the top value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/gameover_seq.sv
// Game-over overlay sequencer.
// After player death waits DEATH_DELAY frames, wipes the overlay in from the
// top, holds it for at least MIN_SHOW frames, then arms a restart button and
// emits a single-cycle restart_req.
// Optional: define GAMEOVER_SEQ_BLINK_EN to blink the "press button" prompt
// with a half-period of BLINK_FRAMES frames while armed.
module gameover_seq
  import gameover_pkg::*;
#(
  parameter int unsigned GO_H         = GO_H_DEFAULT,
  parameter int unsigned REVEAL_STEP  = 32,
  parameter int unsigned DEATH_DELAY  = 60,
  parameter int unsigned MIN_SHOW     = 30,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       player_dead,
  input  logic       any_button,
  output logic       game_over_screen,
  output logic [9:0] reveal_rows,
  output logic       prompt_visible,
  output logic       restart_req,
  output logic [2:0] state_dbg
);

  localparam logic [9:0]             GO_H_ROWS  = 10'(GO_H);
  localparam logic [FRAME_CNT_W-1:0] DELAY_TERM = FRAME_CNT_W'(DEATH_DELAY - 1);
  localparam logic [FRAME_CNT_W-1:0] SHOW_MIN   = FRAME_CNT_W'(MIN_SHOW);

  go_state_t              state;
  go_state_t              state_nxt;
  logic                   btn_q;
  logic                   btn_edge;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   frame_at_term;
  logic [9:0]             rows_step;
  logic [9:0]             rows_nxt;
  logic                   prompt_nxt;

  assign btn_edge  = any_button && !btn_q;
  assign rows_step = reveal_step(reveal_rows, 11'(REVEAL_STEP), 11'(GO_H));
  assign state_dbg = state;

  // Frames spent in the current state; restarts on every state change.
  go_frame_counter #(
    .W(FRAME_CNT_W)
  ) u_frame_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_nxt != state),
    .tick   (frame_tick),
    .term   (DELAY_TERM),
    .count  (frame_cnt),
    .at_term(frame_at_term)
  );

  // Next-state decode; losing player_dead past DELAY abandons to CLEAR.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (player_dead) state_nxt = DELAY;
      end
      DELAY: begin
        if (!player_dead)                       state_nxt = IDLE;
        else if (frame_tick && frame_at_term)   state_nxt = REVEAL;
      end
      REVEAL: begin
        if (!player_dead)                               state_nxt = CLEAR;
        else if (btn_edge)                              state_nxt = HOLD;
        else if (frame_tick && rows_step == GO_H_ROWS)  state_nxt = HOLD;
      end
      HOLD: begin
        if (!player_dead)                               state_nxt = CLEAR;
        else if (frame_cnt >= SHOW_MIN && !any_button)  state_nxt = ARMED;
      end
      ARMED: begin
        if (!player_dead)  state_nxt = CLEAR;
        else if (btn_edge) state_nxt = EXIT;
      end
      EXIT: begin
        state_nxt = CLEAR;
      end
      CLEAR: begin
        if (!player_dead) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Wipe height for the next state; a skip lands on GO_H via the HOLD branch.
  always_comb begin
    rows_nxt = '0;
    case (state_nxt)
      REVEAL: begin
        if (state == REVEAL) begin
          rows_nxt = frame_tick ? rows_step : reveal_rows;
        end
      end
      HOLD, ARMED, EXIT: begin
        rows_nxt = GO_H_ROWS;
      end
      default: begin
        rows_nxt = '0;
      end
    endcase
  end

`ifdef GAMEOVER_SEQ_BLINK_EN
  logic [FRAME_CNT_W-1:0] blink_cnt;
  logic [FRAME_CNT_W-1:0] blink_cnt_nxt;
  logic                   blink_at_term;
  logic                   blink_wrap;

  // Blink counter runs modulo two half-periods so its value alone gives the phase.
  assign blink_wrap = (state != ARMED) || (frame_tick && blink_at_term);

  go_frame_counter #(
    .W(FRAME_CNT_W)
  ) u_blink_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (blink_wrap),
    .tick   (frame_tick),
    .term   (FRAME_CNT_W'(2 * BLINK_FRAMES - 1)),
    .count  (blink_cnt),
    .at_term(blink_at_term)
  );

  // Prompt is lit during the first half-period, starting lit on ARMED entry.
  always_comb begin
    if (blink_wrap) begin
      blink_cnt_nxt = '0;
    end else if (frame_tick) begin
      blink_cnt_nxt = blink_cnt + FRAME_CNT_W'(1);
    end else begin
      blink_cnt_nxt = blink_cnt;
    end
    prompt_nxt = (state_nxt == ARMED) &&
                 (blink_cnt_nxt < FRAME_CNT_W'(BLINK_FRAMES));
  end
`else
  // Steady prompt whenever the restart button is armed.
  always_comb begin
    prompt_nxt = (state_nxt == ARMED);
  end
`endif

  // State, button history and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      btn_q            <= 1'b0;
      game_over_screen <= 1'b0;
      reveal_rows      <= '0;
      prompt_visible   <= 1'b0;
      restart_req      <= 1'b0;
    end else begin
      state            <= state_nxt;
      btn_q            <= any_button;
      game_over_screen <= (state_nxt == REVEAL) || (state_nxt == HOLD) ||
                          (state_nxt == ARMED)  || (state_nxt == EXIT);
      reveal_rows      <= rows_nxt;
      prompt_visible   <= prompt_nxt;
      restart_req      <= (state_nxt == EXIT);
    end
  end

endmodule

// File: tb/tb_gameover_seq.sv
// Testbench for gameover_seq: a fixed vector table for the main sequence,
// hand-written corner sequences, and randomized stimulus against a
// behavioural model, all checked every cycle.
module tb_gameover_seq;

  localparam int DD   = 4;
  localparam int STEP = 64;
  localparam int GOH  = 512;
  localparam int MINS = 2;
  localparam int BF   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       player_dead = 1'b0;
  logic       any_button = 1'b0;
  logic       game_over_screen;
  logic [9:0] reveal_rows;
  logic       prompt_visible;
  logic       restart_req;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  gameover_seq #(
    .GO_H        (GOH),
    .REVEAL_STEP (STEP),
    .DEATH_DELAY (DD),
    .MIN_SHOW    (MINS),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .player_dead     (player_dead),
    .any_button      (any_button),
    .game_over_screen(game_over_screen),
    .reveal_rows     (reveal_rows),
    .prompt_visible  (prompt_visible),
    .restart_req     (restart_req),
    .state_dbg       (state_dbg)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: states numbered 0..6, frames = ticks since entering
  // the current state, k = ticks spent in the armed state.
  int m_st = 0, m_frames = 0, m_rows = 0, m_k = 0;
  bit m_btnq = 0, m_gos = 0, m_prompt = 0, m_req = 0;

  task automatic model_step();
    int ns, nr;
    bit edge_b;
    if (rst) begin
      m_st = 0; m_frames = 0; m_rows = 0; m_k = 0;
      m_btnq = 0; m_gos = 0; m_prompt = 0; m_req = 0;
      return;
    end
    edge_b = any_button && !m_btnq;
    ns = m_st;
    nr = m_rows;
    case (m_st)
      0: if (player_dead) ns = 1;
      1: if (!player_dead) ns = 0;
         else if (frame_tick && m_frames == DD - 1) begin ns = 2; nr = 0; end
      2: if (!player_dead) ns = 6;
         else if (edge_b) ns = 3;
         else if (frame_tick) begin
           nr = (m_rows + STEP > GOH) ? GOH : m_rows + STEP;
           if (nr == GOH) ns = 3;
         end
      3: if (!player_dead) ns = 6;
         else if (m_frames >= MINS && !any_button) ns = 4;
      4: if (!player_dead) ns = 6;
         else if (edge_b) ns = 5;
      5: ns = 6;
      6: if (!player_dead) ns = 0;
      default: ns = 0;
    endcase
    if (ns inside {3, 4, 5}) nr = GOH;
    else if (ns != 2) nr = 0;
    m_k = (m_st == 4) ? m_k + (frame_tick ? 1 : 0) : 0;
    if (ns != m_st) m_frames = 0;
    else if (frame_tick && m_frames < 255) m_frames = m_frames + 1;
    m_gos = ns inside {2, 3, 4, 5};
    m_req = (ns == 5);
`ifdef GAMEOVER_SEQ_BLINK_EN
    m_prompt = (ns == 4) && (((m_k / BF) % 2) == 0);
`else
    m_prompt = (ns == 4);
`endif
    m_btnq = any_button;
    m_st   = ns;
    m_rows = nr;
  endtask

  // One clock: model sees the same inputs the DUT samples; compare after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("model_gos",    int'(game_over_screen), int'(m_gos));
    chk("model_rows",   int'(reveal_rows),      m_rows);
    chk("model_prompt", int'(prompt_visible),   int'(m_prompt));
    chk("model_req",    int'(restart_req),      int'(m_req));
    chk("model_state",  int'(state_dbg),        m_st);
  endtask

  task automatic set_in(input bit r, input bit d, input bit t, input bit b);
    rst = r; player_dead = d; frame_tick = t; any_button = b;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0);
  endtask

  task automatic goto_armed();
    do_reset();
    set_in(0, 1, 0, 0); cyc();
    for (int i = 0; i < DD; i++) begin set_in(0, 1, 1, 0); cyc(); end
    set_in(0, 1, 0, 1); cyc();
    set_in(0, 1, 0, 0); cyc();
    for (int i = 0; i < MINS; i++) begin set_in(0, 1, 1, 0); cyc(); end
    set_in(0, 1, 0, 0); cyc();
    chk("goto_armed_state", int'(state_dbg), 4);
  endtask

  typedef struct {
    bit r, d, t, b;
    int gos, rows, prompt, req, st;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input bit r, input bit d, input bit t, input bit b,
                              input int gos, input int rows, input int prompt,
                              input int req, input int st);
    vec_t v;
    v.r = r; v.d = d; v.t = t; v.b = b;
    v.gos = gos; v.rows = rows; v.prompt = prompt; v.req = req; v.st = st;
    tv.push_back(v);
  endfunction

  initial begin
    int seen_gos, seen_req, req_cnt;
    int pat[5];

    // Full sequence: reset, death delay, 8-step wipe, hold, arm, restart, clear.
    add(1, 0, 0, 0, 0, 0,   0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 1);
    for (int i = 0; i < DD - 1; i++) add(0, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0,   0, 0, 2);
    for (int i = 1; i <= 8; i++) add(0, 1, 1, 0, 1, 64 * i, 0, 0, (i == 8) ? 3 : 2);
    add(0, 1, 0, 0, 1, 512, 0, 0, 3);
    add(0, 1, 1, 0, 1, 512, 0, 0, 3);
    add(0, 1, 1, 0, 1, 512, 0, 0, 3);
    add(0, 1, 0, 0, 1, 512, 1, 0, 4);
    add(0, 1, 0, 1, 1, 512, 0, 1, 5);
    add(0, 1, 0, 1, 0, 0,   0, 0, 6);
    add(0, 1, 0, 0, 0, 0,   0, 0, 6);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0);

    foreach (tv[i]) begin
      set_in(tv[i].r, tv[i].d, tv[i].t, tv[i].b);
      cyc();
      chk($sformatf("tv%0d_gos", i),    int'(game_over_screen), tv[i].gos);
      chk($sformatf("tv%0d_rows", i),   int'(reveal_rows),      tv[i].rows);
      chk($sformatf("tv%0d_prompt", i), int'(prompt_visible),   tv[i].prompt);
      chk($sformatf("tv%0d_req", i),    int'(restart_req),      tv[i].req);
      chk($sformatf("tv%0d_state", i),  int'(state_dbg),        tv[i].st);
    end

    // Skip: button at rows=128 jumps to full height; held button blocks arming.
    do_reset();
    set_in(0, 1, 0, 0); cyc();
    for (int i = 0; i < DD + 2; i++) begin set_in(0, 1, 1, 0); cyc(); end
    chk("skip_pre_rows", int'(reveal_rows), 128);
    set_in(0, 1, 0, 1); cyc();
    chk("skip_rows", int'(reveal_rows), 512);
    chk("skip_state", int'(state_dbg), 3);
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 0, 1); cyc();
      chk("skip_held_state", int'(state_dbg), 3);
    end
    set_in(0, 1, 0, 0); cyc();
    chk("skip_release_state", int'(state_dbg), 3);
    set_in(0, 1, 1, 0); cyc();
    set_in(0, 1, 1, 0); cyc();
    chk("skip_two_ticks_state", int'(state_dbg), 3);
    set_in(0, 1, 0, 0); cyc();
    chk("skip_armed_state", int'(state_dbg), 4);

    // Restart: exactly one restart_req, overlay off after it, CLEAR until alive.
    req_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 0, 1); cyc();
      if (restart_req) req_cnt++;
      if (i == 1) chk("restart_gos_drop", int'(game_over_screen), 0);
    end
    chk("restart_pulse_count", req_cnt, 1);
    chk("restart_clear_state", int'(state_dbg), 6);
    set_in(0, 0, 0, 0); cyc();
    chk("restart_idle_state", int'(state_dbg), 0);

    // Abort: death clears after two delay ticks, overlay never shown.
    do_reset();
    seen_gos = 0; seen_req = 0;
    set_in(0, 1, 0, 0); cyc();
    seen_gos += int'(game_over_screen); seen_req += int'(restart_req);
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 1, 0); cyc();
      seen_gos += int'(game_over_screen); seen_req += int'(restart_req);
    end
    set_in(0, 0, 0, 0); cyc();
    seen_gos += int'(game_over_screen); seen_req += int'(restart_req);
    chk("abort_state", int'(state_dbg), 0);
    chk("abort_gos_seen", seen_gos, 0);
    chk("abort_req_seen", seen_req, 0);

    // Reset while armed.
    goto_armed();
    set_in(1, 1, 0, 0); cyc();
    chk("rst_gos", int'(game_over_screen), 0);
    chk("rst_rows", int'(reveal_rows), 0);
    chk("rst_prompt", int'(prompt_visible), 0);
    chk("rst_req", int'(restart_req), 0);
    chk("rst_state", int'(state_dbg), 0);
    set_in(0, 0, 0, 0);

    // Prompt across successive ticks while armed.
`ifdef GAMEOVER_SEQ_BLINK_EN
    pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 1;
`else
    pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 1; pat[4] = 1;
`endif
    goto_armed();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("prompt_pat%0d", i), int'(prompt_visible), pat[i]);
      set_in(0, 1, 1, 0); cyc();
      set_in(0, 1, 0, 0); cyc();
    end

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 499) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 79) == 0) player_dead = !player_dead;
      if ($urandom_range(0, 5) == 0)  any_button  = !any_button;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
